nano_mem_resp: RTL and testbench
================================

# nano_mem_resp

Synthesizable memory responder for the NanoCPU memory bus: the slave end of the CPU's `address`/`dataR`/`dataW`/`ce`/`we` interface. It backs a 256×16 RAM and zero-fills it after every reset. It then accepts a program/data image through a valid/ready load port, and finally releases the CPU from hold to run. It also keeps write-trace registers (count, last address, last data) so that top-level logic and benches can observe program output.

## Interface
- `AW`, default 8: address width; the memory has 2^AW words.
- `DW`, default 16: data word width.
- `ck` in 1: clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `address` in AW: CPU word address.
- `dataR` out DW: read data to the CPU.
- `dataW` in DW: write data from the CPU.
- `ce` in 1: CPU chip enable. Accepted, but has no effect on reads or writes.
- `we` in 1: CPU write enable.
- `ld_valid` in 1: loader word valid.
- `ld_ready` out 1: loader may transfer.
- `ld_addr` in AW: loader target address.
- `ld_data` in DW: loader data word.
- `ld_done` in 1: loader image complete.
- `cpu_hold` out 1: high while the CPU must be held in reset.
- `wr_count` out 16: number of CPU writes in RUN, saturating.
- `last_wr_addr` out AW: address of the most recent CPU write in RUN.
- `last_wr_data` out DW: data of the most recent CPU write in RUN.

## Operation
- FSM states are CLEAR, LOAD and RUN. Asynchronous `rst` forces CLEAR and sets `clr_idx=0`, `wr_count=0`, `last_wr_addr=0` and `last_wr_data=0`.
- Reset values of the outputs: `cpu_hold=1`, `ld_ready=0`, `wr_count=0`, `last_wr_addr=0`, `last_wr_data=0`. Memory contents are not reset directly; CLEAR overwrites them.
- **CLEAR state**
  - Every cycle writes 0 to `mem[clr_idx]` and increments `clr_idx`.
  - When `clr_idx` = 2^AW−1, that location is written and the FSM goes to LOAD. CLEAR lasts exactly 2^AW cycles; `clr_idx` wraps to 0.
- **LOAD state**
  - `ld_ready=1`.
  - When `ld_valid` and `ld_ready` are both high at a clock edge, `mem[ld_addr]` ← `ld_data`.
  - When `ld_done` is high at a clock edge, the FSM goes to RUN. If `ld_valid` is high in the same cycle, that word is still written.
  - Repeated writes to the same `ld_addr` are allowed; the last one wins.
- **RUN state**
  - `ld_ready=0`, and the loader inputs are ignored.
  - When `we=1` at a clock edge, `mem[address]` ← `dataW`, `last_wr_addr` ← `address`, `last_wr_data` ← `dataW`, and `wr_count` increments. `wr_count` saturates at 16'hFFFF.
  - RUN is left only by `rst`.
- In CLEAR and LOAD, CPU `we` is ignored: no memory write, no trace update.
- `cpu_hold` = (state ≠ RUN), decoded directly from the state register.
- Reads: `dataR` = `mem[address]`, combinational in every state, regardless of `ce`.
- Reset mid-operation, in any state: the block returns to CLEAR immediately, the trace is lost, and the memory is re-zeroed.

## Timing
- Read latency is 0 cycles: `dataR` follows `address` within the same cycle.
- Write latency: a write sampled at edge N is visible on `dataR` after edge N, in the same cycle. A read of the written address in the cycle before edge N returns the old value.
- Read/write collision on the same address in one cycle: `dataR` shows the old value until the edge.
- Loader handshake: one word per cycle at full rate when `ld_valid` is held high. `ld_ready` is high for the whole LOAD state and never deasserts mid-stream.
- Release timing: `ld_done` sampled at edge N ⇒ `cpu_hold` falls and `ld_ready` falls after edge N. The first CPU write can be accepted at edge N+1.
- Reset to LOAD: `rst` falls, then after 2^AW rising edges `ld_ready` = 1. With AW=8 that is 256 edges.
- Trace outputs update at the same edge as the memory write.

## Test plan
- **Reset release.** Deassert `rst` and count edges while `cpu_hold`=1 and `ld_ready`=0. Required: exactly 256 edges, then `ld_ready`=1. In LOAD, addresses 0, 15 and 255 all read 16'h0000.
- **Load and release.** Load `mem[3]`=16'h01E3 and `mem[30]`=16'h000A, then pulse `ld_done`. Required: on the next cycle `cpu_hold`=0 and `ld_ready`=0; `address`=30 gives `dataR`=16'h000A; `address`=3 gives `dataR`=16'h01E3.
- **Simultaneous last word and done.** In one cycle set `ld_valid`=1, `ld_addr`=12, `ld_data`=16'hF000 and `ld_done`=1. Required: state is RUN and `mem[12]` reads 16'hF000.
- **CPU write in RUN.** Drive `we`=1, `address`=15, `dataW`=16'h0001 for one edge. Required after the edge: `dataR`@15 = 16'h0001, `wr_count`=1, `last_wr_addr`=15, `last_wr_data`=16'h0001. Ten consecutive writes give `wr_count`=10.
- **Ignored CPU writes.** Drive `we`=1, `address`=20, `dataW`=16'hBEEF during LOAD. Required: `mem[20]` stays 0 and `wr_count`=0. Also force `wr_count` to saturation and write again. Required: `wr_count` remains 16'hFFFF.
- **Reset mid-RUN.** After writing `mem[15]`=16'h0001, pulse `rst` between clock edges. Required: the outputs return to their reset values immediately. After 256 CLEAR cycles, `mem[15]` reads 16'h0000 and `wr_count`=0.

Source files
------------

// File: rtl/nano_mem_resp_if.sv
// nano_mem_resp_if
// Bundles the NanoCPU memory bus, the image loader port and the write-trace
// outputs of the memory responder.
//   slave  modport : used by nano_mem_resp (drives dataR, ld_ready, cpu_hold,
//                    wr_count, last_wr_addr, last_wr_data)
//   master modport : used by the CPU/loader side (drives address, dataW, ce,
//                    we, ld_valid, ld_addr, ld_data, ld_done)
interface nano_mem_resp_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    // CPU memory bus
    logic [AW-1:0] address;
    logic [DW-1:0] dataR;
    logic [DW-1:0] dataW;
    logic          ce;
    logic          we;
    // image loader
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_done;
    // run control and write trace
    logic          cpu_hold;
    logic [15:0]   wr_count;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;

    modport slave (
        input  address, dataW, ce, we,
        input  ld_valid, ld_addr, ld_data, ld_done,
        output dataR, ld_ready, cpu_hold,
        output wr_count, last_wr_addr, last_wr_data
    );

    modport master (
        output address, dataW, ce, we,
        output ld_valid, ld_addr, ld_data, ld_done,
        input  dataR, ld_ready, cpu_hold,
        input  wr_count, last_wr_addr, last_wr_data
    );
endinterface

// File: rtl/nano_mem_resp.sv
// nano_mem_resp
// Memory responder for the NanoCPU bus. After reset it zero-fills a
// 2^AW x DW RAM (CLEAR), then accepts an image through a valid/ready loader
// port (LOAD), then releases the CPU and serves its reads/writes (RUN) while
// tracing CPU writes.
// Ports:
//   ck   : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : nano_mem_resp_if.slave -- CPU bus (address/dataR/dataW/ce/we),
//          loader (ld_valid/ld_ready/ld_addr/ld_data/ld_done), cpu_hold and
//          trace outputs (wr_count/last_wr_addr/last_wr_data)
module nano_mem_resp #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic                ck,
    input  logic                rst,
    nano_mem_resp_if.slave      bus
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] clr_idx_reg, clr_idx_next;
    logic [15:0]   wr_count_reg, wr_count_next;
    logic [AW-1:0] last_wr_addr_reg, last_wr_addr_next;
    logic [DW-1:0] last_wr_data_reg, last_wr_data_next;

    // single write port shared by the clear sweep, the loader and the CPU;
    // the FSM state decides which of them owns it
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic [DW-1:0] mem [0:DEPTH-1];

    // chip enable is part of the bus but deliberately has no effect
    logic unused_ce;
    assign unused_ce = bus.ce;

    // ------------------------------------------------------------------
    // state and trace registers
    // ------------------------------------------------------------------
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_CLEAR;
            clr_idx_reg      <= '0;
            wr_count_reg     <= '0;
            last_wr_addr_reg <= '0;
            last_wr_data_reg <= '0;
        end else begin
            state_reg        <= state_next;
            clr_idx_reg      <= clr_idx_next;
            wr_count_reg     <= wr_count_next;
            last_wr_addr_reg <= last_wr_addr_next;
            last_wr_data_reg <= last_wr_data_next;
        end
    end

    // ------------------------------------------------------------------
    // next-state and write-port decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        clr_idx_next      = clr_idx_reg;
        wr_count_next     = wr_count_reg;
        last_wr_addr_next = last_wr_addr_reg;
        last_wr_data_next = last_wr_data_reg;
        mem_we            = 1'b0;
        mem_waddr         = '0;
        mem_wdata         = '0;

        case (state_reg)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                mem_waddr    = clr_idx_reg;
                mem_wdata    = '0;
                // wraps to 0 after the last location, ready for the next reset
                clr_idx_next = clr_idx_reg + 1'b1;
                if (clr_idx_reg == {AW{1'b1}}) begin
                    state_next = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // ld_ready is constantly high here, so valid alone transfers;
                // a word arriving with ld_done is still written
                if (bus.ld_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.ld_addr;
                    mem_wdata = bus.ld_data;
                end
                if (bus.ld_done) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.we) begin
                    mem_we            = 1'b1;
                    mem_waddr         = bus.address;
                    mem_wdata         = bus.dataW;
                    last_wr_addr_next = bus.address;
                    last_wr_data_next = bus.dataW;
                    if (wr_count_reg != 16'hFFFF) begin
                        wr_count_next = wr_count_reg + 16'd1;
                    end
                end
            end

            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RAM: synchronous write, asynchronous read (zero-latency reads;
    // a same-cycle read of the written word sees the old value)
    // ------------------------------------------------------------------
    always_ff @(posedge ck) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.dataR        = mem[bus.address];
    assign bus.cpu_hold     = (state_reg != ST_RUN);
    assign bus.ld_ready     = (state_reg == ST_LOAD);
    assign bus.wr_count     = wr_count_reg;
    assign bus.last_wr_addr = last_wr_addr_reg;
    assign bus.last_wr_data = last_wr_data_reg;

endmodule

// File: tb/tb_nano_mem_resp.sv
// tb_nano_mem_resp
// Directed bench for nano_mem_resp: reset values, clear duration, loader
// handshake, release to RUN, CPU writes with trace, ignored writes, write
// counter saturation and reset in the middle of RUN.
module tb_nano_mem_resp;

    localparam int AW = 8;
    localparam int DW = 16;

    logic ck;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   edges;

    nano_mem_resp_if #(.AW(AW), .DW(DW)) bus ();

    nano_mem_resp #(.AW(AW), .DW(DW)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("PASS %s observed=%0h", tag, obs);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst          = 1'b1;
        bus.address  = '0;
        bus.dataW    = '0;
        bus.ce       = 1'b1;
        bus.we       = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        bus.ld_done  = 1'b0;

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_cpu_hold", bus.cpu_hold, 1'b1);
        check("rst_ld_ready", bus.ld_ready, 1'b0);
        check("rst_wr_count", bus.wr_count, 16'h0000);
        check("rst_last_addr", bus.last_wr_addr, 8'h00);
        check("rst_last_data", bus.last_wr_data, 16'h0000);
        $display("[TB] reset values checked");

        // ---------------- clear duration ----------------
        #3 rst = 1'b0;
        edges = 0;
        while (bus.ld_ready !== 1'b1 && edges < 1000) begin
            tick();
            edges++;
        end
        check("clear_edges", edges, 256);
        check("load_cpu_hold", bus.cpu_hold, 1'b1);
        $display("[TB] clear finished after %0d edges", edges);

        // ---------------- memory zeroed ----------------
        bus.address = 8'd0;   #1 check("zero_rd_0", bus.dataR, 16'h0000);
        bus.address = 8'd15;  #1 check("zero_rd_15", bus.dataR, 16'h0000);
        bus.address = 8'd255; #1 check("zero_rd_255", bus.dataR, 16'h0000);
        $display("[TB] zero reads at 0/15/255");

        // ---------------- CPU write ignored in LOAD ----------------
        bus.we = 1'b1; bus.address = 8'd20; bus.dataW = 16'hBEEF;
        tick();
        bus.we = 1'b0;
        #1 check("load_we_mem20", bus.dataR, 16'h0000);
        check("load_we_count", bus.wr_count, 16'h0000);
        check("load_we_last_data", bus.last_wr_data, 16'h0000);
        $display("[TB] CPU write during LOAD ignored");

        // ---------------- loader stream ----------------
        bus.ld_valid = 1'b1;
        bus.ld_addr = 8'd3;  bus.ld_data = 16'h01E3; tick();
        check("ld_ready_stream", bus.ld_ready, 1'b1);
        bus.ld_addr = 8'd30; bus.ld_data = 16'h000A; tick();
        bus.ld_addr = 8'd5;  bus.ld_data = 16'h1111; tick();
        bus.ld_addr = 8'd5;  bus.ld_data = 16'h2222; tick();
        check("ld_ready_hold", bus.ld_ready, 1'b1);
        bus.ld_addr = 8'd12; bus.ld_data = 16'hF000; bus.ld_done = 1'b1;
        tick();
        bus.ld_valid = 1'b0; bus.ld_done = 1'b0;
        check("run_cpu_hold", bus.cpu_hold, 1'b0);
        check("run_ld_ready", bus.ld_ready, 1'b0);
        bus.address = 8'd30; #1 check("ld_rd_30", bus.dataR, 16'h000A);
        bus.address = 8'd3;  #1 check("ld_rd_3", bus.dataR, 16'h01E3);
        bus.address = 8'd12; #1 check("ld_rd_12", bus.dataR, 16'hF000);
        bus.address = 8'd5;  #1 check("ld_rd_5_last_wins", bus.dataR, 16'h2222);
        $display("[TB] image loaded and CPU released");

        // ---------------- loader ignored in RUN ----------------
        bus.ld_valid = 1'b1; bus.ld_addr = 8'd40; bus.ld_data = 16'h7777;
        tick();
        bus.ld_valid = 1'b0;
        bus.address = 8'd40; #1 check("run_ld_ignored", bus.dataR, 16'h0000);
        $display("[TB] loader ignored in RUN");

        // ---------------- CPU write in RUN ----------------
        bus.we = 1'b1; bus.address = 8'd15; bus.dataW = 16'h0001;
        #1 check("collide_old", bus.dataR, 16'h0000);
        tick();
        bus.we = 1'b0;
        check("wr_rd_15", bus.dataR, 16'h0001);
        check("wr_count_1", bus.wr_count, 16'd1);
        check("wr_last_addr", bus.last_wr_addr, 8'd15);
        check("wr_last_data", bus.last_wr_data, 16'h0001);
        $display("[TB] CPU write addr=15 data=0001");

        for (int i = 0; i < 9; i++) begin
            bus.we = 1'b1;
            bus.address = 8'(100 + i);
            bus.dataW = 16'(16'h0100 + i);
            tick();
        end
        bus.we = 1'b0;
        check("wr_count_10", bus.wr_count, 16'd10);
        check("wr10_last_addr", bus.last_wr_addr, 8'd108);
        check("wr10_last_data", bus.last_wr_data, 16'h0108);
        bus.address = 8'd100; #1 check("wr_rd_100", bus.dataR, 16'h0100);
        $display("[TB] ten CPU writes counted");

        // ---------------- reset mid-RUN ----------------
        #2 rst = 1'b1;
        #1 check("mid_rst_cpu_hold", bus.cpu_hold, 1'b1);
        check("mid_rst_ld_ready", bus.ld_ready, 1'b0);
        check("mid_rst_count", bus.wr_count, 16'h0000);
        check("mid_rst_last_addr", bus.last_wr_addr, 8'h00);
        check("mid_rst_last_data", bus.last_wr_data, 16'h0000);
        #1 rst = 1'b0;
        edges = 0;
        while (bus.ld_ready !== 1'b1 && edges < 1000) begin
            tick();
            edges++;
        end
        check("reclear_edges", edges, 256);
        bus.address = 8'd15; #1 check("reclear_rd_15", bus.dataR, 16'h0000);
        check("reclear_count", bus.wr_count, 16'h0000);
        $display("[TB] reset mid-RUN re-zeroed memory");

        // ---------------- saturation ----------------
        bus.ld_done = 1'b1; tick(); bus.ld_done = 1'b0;
        check("sat_run", bus.cpu_hold, 1'b0);
        bus.we = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus.address = 8'(i);
            bus.dataW = 16'(i);
            tick();
        end
        bus.we = 1'b0;
        check("sat_reach", bus.wr_count, 16'hFFFF);
        bus.we = 1'b1; bus.address = 8'd7; bus.dataW = 16'hABCD;
        tick();
        bus.we = 1'b0;
        check("sat_hold", bus.wr_count, 16'hFFFF);
        check("sat_last_data", bus.last_wr_data, 16'hABCD);
        $display("[TB] write counter saturated at FFFF");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
